// File: rtl/nfc_read_burst_sequencer.sv
// rtl/nfc_read_burst_sequencer.sv - NAND read-burst sequencer driving RE toggles and physical-input capture
//
// Sequences one NAND data-out burst: waits for the input delay line to be ready,
// resets the capture path, issues the RE preamble, toggles RE once per 16-bit
// word, holds the capture write-enable through the postamble, then drains the
// captured stream until the last beat (or the expected word count) is seen.
//
// Ports:
//   iSystemClock, iReset                  clock, asynchronous active-high reset
//   iCMDValid / oCMDReady, iByteCount     burst request handshake and length in bytes
//   iPI_DelayReady                        delay-line calibration done
//   oPI_BufferReset, oPI_Buff_WE          capture path reset and write-enable
//   oRE                                   NAND read-enable (idle high)
//   iPI_Buff_Valid/Ready/Last             monitored capture output stream
//   oDone, oError, oBusy                  completion pulse, error pulse, activity flag
module nfc_read_burst_sequencer #(
    parameter int BufferResetCycles = 4,
    parameter int PreambleCycles    = 3,
    parameter int PostambleCycles   = 3,
    parameter int DrainTimeout      = 1023
) (
    input  logic        iSystemClock,
    input  logic        iReset,
    input  logic        iCMDValid,
    output logic        oCMDReady,
    input  logic [15:0] iByteCount,
    input  logic        iPI_DelayReady,
    output logic        oPI_BufferReset,
    output logic        oPI_Buff_WE,
    output logic        oRE,
    input  logic        iPI_Buff_Valid,
    input  logic        iPI_Buff_Ready,
    input  logic        iPI_Buff_Last,
    output logic        oDone,
    output logic        oError,
    output logic        oBusy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITDLY, S_BUFRST, S_PREAMBLE,
        S_TOGGLE, S_POSTAMBLE, S_DRAIN, S_DONE
    } state_t;

    localparam logic [16:0] BUFRST_LEN = 17'(BufferResetCycles);
    localparam logic [16:0] PRE_LEN    = 17'(PreambleCycles);
    localparam logic [16:0] POST_LEN   = 17'(PostambleCycles);
    localparam logic [16:0] DRAIN_LIM  = 17'(DrainTimeout);

    state_t      state_q, state_d;
    // Shared phase counter; 17 bits so 2*0x8000 toggle cycles fit without wrapping.
    // In DRAIN it counts idle cycles since the last beat.
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] words_q, words_d;
    logic [15:0] beats_q, beats_d;

    logic cmd_ready_q, cmd_ready_d;
    logic buf_reset_q, buf_reset_d;
    logic we_q, we_d;
    logic re_q, re_d;
    logic done_q, done_d;
    logic error_q, error_d;
    logic busy_q, busy_d;

    logic        beat;
    logic [16:0] cnt_inc;
    logic [16:0] toggle_len;
    logic [15:0] beats_inc;

    assign beat       = iPI_Buff_Valid & iPI_Buff_Ready;
    assign cnt_inc    = cnt_q + 17'd1;
    assign toggle_len = {words_q, 1'b0};
    assign beats_inc  = beats_q + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        beats_d = beats_q;
        error_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iCMDValid) begin
                    if (iByteCount == 16'd0) begin
                        error_d = 1'b1;
                    end else begin
                        // Round odd byte counts up to whole 16-bit words.
                        words_d = {1'b0, iByteCount[15:1]} + {15'd0, iByteCount[0]};
                        state_d = S_WAITDLY;
                    end
                end
            end
            S_WAITDLY: begin
                if (iPI_DelayReady) begin
                    state_d = S_BUFRST;
                    cnt_d   = 17'd0;
                end
            end
            S_BUFRST: begin
                if (cnt_inc == BUFRST_LEN) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = 17'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PREAMBLE: begin
                if (cnt_inc == PRE_LEN) begin
                    state_d = S_TOGGLE;
                    cnt_d   = 17'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_TOGGLE: begin
                if (cnt_inc == toggle_len) begin
                    state_d = S_POSTAMBLE;
                    cnt_d   = 17'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_POSTAMBLE: begin
                if (cnt_inc == POST_LEN) begin
                    state_d = S_DRAIN;
                    cnt_d   = 17'd0;
                    beats_d = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                // A beat wins over a timeout landing in the same cycle.
                if (beat) begin
                    cnt_d   = 17'd0;
                    beats_d = beats_inc;
                    if (iPI_Buff_Last || (beats_inc == words_q)) begin
                        state_d = S_DONE;
                    end
                end else if (cnt_inc >= DRAIN_LIM) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered value lines up
    // with the state it describes.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        buf_reset_d = (state_d == S_BUFRST);
        we_d        = (state_d == S_TOGGLE) || (state_d == S_POSTAMBLE);
        done_d      = (state_d == S_DONE);
        re_d        = 1'b1;
        if (state_d == S_PREAMBLE) begin
            re_d = 1'b0;
        end else if (state_d == S_TOGGLE) begin
            re_d = ~cnt_d[0];
        end
    end

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 17'd0;
            words_q     <= 16'd0;
            beats_q     <= 16'd0;
            cmd_ready_q <= 1'b1;
            buf_reset_q <= 1'b1;
            we_q        <= 1'b0;
            re_q        <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            beats_q     <= beats_d;
            cmd_ready_q <= cmd_ready_d;
            buf_reset_q <= buf_reset_d;
            we_q        <= we_d;
            re_q        <= re_d;
            done_q      <= done_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign oCMDReady       = cmd_ready_q;
    assign oPI_BufferReset = buf_reset_q;
    assign oPI_Buff_WE     = we_q;
    assign oRE             = re_q;
    assign oDone           = done_q;
    assign oError          = error_q;
    assign oBusy           = busy_q;

endmodule

// File: doc/nfc_read_burst_sequencer.md
NFC_READ_BURST_SEQUENCER -- requirements
Module: nfc_read_burst_sequencer

Interface
REQ-001 SHALL have parameter BufferResetCycles, default 4, meaning the oPI_BufferReset pulse length in cycles (1..15).
REQ-002 SHALL have parameter PreambleCycles, default 3, meaning the oRE-low read-preamble length in cycles (1..15).
REQ-003 SHALL have parameter PostambleCycles, default 3, meaning the WE-held settle time after the last toggle in cycles (1..15).
REQ-004 SHALL have parameter DrainTimeout, default 1023, meaning the maximum idle cycles tolerated in DRAIN before an error.
REQ-005 SHALL have a single clock and an asynchronous, active-high reset; no other clock is used.
REQ-006 iSystemClock  in  1  sole clock; all logic on rising edge.
REQ-007 iReset  in  1  asynchronous active-high reset.
REQ-008 iCMDValid  in  1  read-burst request valid.
REQ-009 oCMDReady  out  1  sequencer idle, request accepted when iCMDValid & oCMDReady.
REQ-010 iByteCount  in  16  bytes to read, sampled on accept.
REQ-011 iPI_DelayReady  in  1  IDELAYCTRL ready from the physical input.
REQ-012 oPI_BufferReset  out  1  reset to the physical input capture and FIFO.
REQ-013 oPI_Buff_WE  out  1  capture write-enable to the physical input.
REQ-014 oRE  out  1  NAND read-enable toggle; idle high.
REQ-015 iPI_Buff_Valid, iPI_Buff_Ready, iPI_Buff_Last  in  1 each  monitored output stream of the physical input.
REQ-016 oDone  out  1  one-cycle pulse on successful completion.
REQ-017 oError  out  1  one-cycle pulse on rejected command or drain timeout.
REQ-018 oBusy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement the states IDLE, WAITDLY, BUFRST, PREAMBLE, TOGGLE, POSTAMBLE, DRAIN and DONE.
REQ-020 oCMDReady SHALL be 1 only in IDLE; iCMDValid outside IDLE SHALL be ignored.
REQ-021 On accept, the sequencer SHALL latch words = ceil(iByteCount/2) as a 16-bit value (an odd count rounds up) and go to WAITDLY.
REQ-022 On accept with iByteCount = 0, it SHALL pulse oError the next cycle, stay in IDLE, and leave all other outputs unchanged.
REQ-023 WAITDLY SHALL hold until iPI_DelayReady = 1, then enter BUFRST.
REQ-024 BUFRST SHALL drive oPI_BufferReset = 1 for exactly BufferResetCycles cycles, then enter PREAMBLE.
REQ-025 PREAMBLE SHALL drive oRE = 0 for PreambleCycles cycles, then enter TOGGLE.
REQ-026 TOGGLE SHALL last exactly 2*words cycles, with oRE = 1 on even cycles and 0 on odd cycles (one RE period per 16-bit word).
REQ-027 oPI_Buff_WE SHALL be 1 from the first TOGGLE cycle through the last POSTAMBLE cycle, and 0 otherwise.
REQ-028 POSTAMBLE SHALL hold oRE = 1 for PostambleCycles cycles, then enter DRAIN.
REQ-029 DRAIN SHALL count beats (iPI_Buff_Valid & iPI_Buff_Ready).
REQ-030 DRAIN SHALL exit to DONE on a beat with iPI_Buff_Last = 1, or when the beat count reaches words, whichever comes first.
REQ-031 DRAIN's idle counter SHALL reset on each beat; reaching DrainTimeout SHALL pulse oError and return to IDLE without a oDone pulse.
REQ-032 DONE SHALL pulse oDone for 1 cycle and return to IDLE the following cycle.
REQ-033 A beat and a timeout in the same cycle SHALL resolve as a beat (no error).
REQ-034 All counters SHALL be 16-bit and SHALL NOT wrap: words = 0x8000 (iByteCount = 0xFFFF) gives 65536 TOGGLE cycles, using a 17-bit toggle counter.
REQ-035 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-036 While iReset = 1 (asynchronous), the state SHALL be IDLE and outputs SHALL be: oCMDReady = 1 after release, oPI_BufferReset = 1, oPI_Buff_WE = 0, oRE = 1, oDone = 0, oError = 0, oBusy = 0.
REQ-037 oPI_BufferReset SHALL return to 0 on the first clock after iReset is released.
REQ-038 Reset mid-burst SHALL abort immediately and produce no oDone or oError pulse.

Verification
REQ-039 iByteCount = 8, iPI_DelayReady = 1 -> 4 cycles of oPI_BufferReset, 3 cycles of oRE low, 8 TOGGLE cycles (oRE 1,0,1,0...), WE high for 11 cycles; 4 beats with Last on the 4th -> oDone 1 cycle.
REQ-040 iByteCount = 7 -> 4 RE periods, identical to the 8-byte case.
REQ-041 iByteCount = 0 -> oError pulse; oBusy stays 0; oRE stays 1.
REQ-042 iPI_DelayReady held 0 for 50 cycles after accept -> stays in WAITDLY, oPI_BufferReset = 0; asserting it starts BUFRST the next cycle.
REQ-043 In DRAIN, stall iPI_Buff_Valid for 1023 cycles (DrainTimeout default) -> oError pulse and no oDone; a beat on cycle 1023 -> no error.
REQ-044 iReset asserted during TOGGLE -> oRE = 1 and oPI_Buff_WE = 0 asynchronously; after release, a new command completes normally.
